// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: owns the DEPTH-word instruction RAM and arbitrates it between
// a valid/ready program loader and the CPU fetch path. It holds the CPU in
// reset-like stall during boot, streams the program in, pads the remaining
// words with FILL_WORD, and then releases the CPU.
module imem_load_ctrl #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              cpu_run,
    output logic              load_busy,
    output logic [ADDR_W:0]   word_count,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] rd_idx;

    // Loader is only ever offered the port while in LOAD; busy covers LOAD and FILL.
    always_comb begin
        ld_ready  = (state == LOAD);
        load_busy = (state == LOAD) || (state == FILL);
        accept    = ld_valid && (state == LOAD);
    end

    // Single RAM write port shared by loader words and padding writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = FILL_WORD;
        if (state == FILL) begin
            wr_en   = 1'b1;
            wr_data = FILL_WORD;
        end else if (accept) begin
            wr_en   = 1'b1;
            wr_data = ld_data;
        end
    end

    // Instruction RAM: never cleared, so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Boot sequencer: IDLE -> LOAD -> (FILL) -> RUN, with reload from RUN.
    // cpu_run is registered one cycle behind entry to RUN, and is cleared on
    // the same edge that samples a reload request so the CPU stalls at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            word_count <= '0;
            cpu_run    <= 1'b0;
        end else begin
            cpu_run <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state      <= LOAD;
                        wr_ptr     <= '0;
                        word_count <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr     <= wr_ptr + ADDR_W'(1);
                        word_count <= word_count + (ADDR_W+1)'(1);
                        if (wr_ptr == LAST_IDX) begin
                            state <= RUN;
                        end else if (ld_last) begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (wr_ptr == LAST_IDX) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        state      <= LOAD;
                        wr_ptr     <= '0;
                        word_count <= '0;
                        cpu_run    <= 1'b0;
                    end else begin
                        cpu_run    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Fetch path: word-aligned combinational read, masked while held or on a bad pc.
    always_comb begin
        rd_idx   = pc[ADDR_W+1:2];
        addr_err = cpu_run && ((|pc[31:ADDR_W+2]) || (|pc[1:0]));
        if (cpu_run && !addr_err) begin
            instr = mem[rd_idx];
        end else begin
            instr = FILL_WORD;
        end
    end

endmodule
